// File: rtl/exe_pkg.sv
// Shared encodings for the handshaked execute stage: commands, shift types,
// NZCV bit positions, FSM states and the decoded control payload.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } exe_state_e;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] dest;
  } exe_ctrl_t;

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator: memory offset, rotated imm8, or shifted Rm.
module val2_gen
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              mem_op,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] val2_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   imm8_ext;
  logic [SH_W-1:0]     rot_amt;
  logic [SH_W-1:0]     sh_amt;
  logic [2*DATA_W-1:0] rot_src;

  // Rotations take the low half of a doubled word shifted right.
  always_comb begin
    imm8_ext = DATA_W'(shift_operand[7:0]);
    rot_amt  = SH_W'((32'(shift_operand[11:8]) * 32'd2) % DATA_W);
    sh_amt   = SH_W'(32'(shift_operand[11:7]) % DATA_W);
    rot_src  = '0;
    val2_c   = '0;
    if (mem_op) begin
      val2_c = DATA_W'(shift_operand);
    end else if (imm) begin
      rot_src = {imm8_ext, imm8_ext} >> rot_amt;
      val2_c  = rot_src[DATA_W-1:0];
    end else begin
      case (shift_operand[6:5])
        SH_LSL: val2_c = val_rm << sh_amt;
        SH_LSR: val2_c = val_rm >> sh_amt;
        SH_ASR: val2_c = $unsigned($signed(val_rm) >>> sh_amt);
        SH_ROR: begin
          rot_src = {val_rm, val_rm} >> sh_amt;
          val2_c  = rot_src[DATA_W-1:0];
        end
        default: val2_c = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_hs.sv
// Handshaked execute stage: ALU, iterative multiplier, NZCV register,
// branch target and a valid/ready output register toward MEM.
module exe_stage_hs
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MUL_STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic              i_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [3:0]        dest_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       imm24_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [3:0]        dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              branch_taken_out,
  output logic [DATA_W-1:0] branch_addr_out,
  output logic [3:0]        status_out
);

  localparam int unsigned ITER  = DATA_W / MUL_STEP_BITS;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam int unsigned SUM_W = DATA_W + 1;

  exe_state_e        state, state_nxt;
  exe_ctrl_t         in_ctrl, hold_ctrl, nxt_ctrl;
  logic [DATA_W-1:0] val2, alu_res, baddr_in, mul_part;
  logic [DATA_W-1:0] mcand, mplier, acc, hold_rm, hold_baddr;
  logic [DATA_W-1:0] nxt_res, nxt_rm, nxt_baddr;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  sum;
  logic [3:0]        alu_flags, nxt_flags;
  logic              accept, is_mul, mul_load, load, is_add, is_sub;

  val2_gen #(.DATA_W(DATA_W)) u_val2 (
    .mem_op        (mem_r_en_in | mem_w_en_in),
    .imm           (i_in),
    .shift_operand (shift_operand_in),
    .val_rm        (val_rm_in),
    .val2_c        (val2)
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (exe_cmd_in == CMD_MUL);
  assign mul_load = (state == ST_DONE) && (!out_valid || out_ready) && !flush;
  assign load     = (accept && !is_mul) || mul_load;
  assign baddr_in = pc_in + DATA_W'({{DATA_W{imm24_in[23]}}, imm24_in, 2'b00});
  assign mul_part = mcand * DATA_W'(mplier[MUL_STEP_BITS-1:0]);

  always_comb begin
    in_ctrl.wb_en    = wb_en_in;
    in_ctrl.mem_r_en = mem_r_en_in;
    in_ctrl.mem_w_en = mem_w_en_in;
    in_ctrl.b        = b_in;
    in_ctrl.s        = s_in;
    in_ctrl.dest     = dest_in;
  end

  // Single-cycle ALU; carry-in of ADC/SBC is the live C flag.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_flags = status_out;
    is_add    = 1'b0;
    is_sub    = 1'b0;
    case (exe_cmd_in)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD: begin sum = {1'b0, val_rn_in} + {1'b0, val2}; is_add = 1'b1; end
      CMD_ADC: begin
        sum    = {1'b0, val_rn_in} + {1'b0, val2} + SUM_W'(status_out[FLAG_C]);
        is_add = 1'b1;
      end
      CMD_SUB: begin sum = {1'b0, val_rn_in} + {1'b0, ~val2} + SUM_W'(1'b1); is_sub = 1'b1; end
      CMD_SBC: begin
        sum    = {1'b0, val_rn_in} + {1'b0, ~val2} + SUM_W'(status_out[FLAG_C]);
        is_sub = 1'b1;
      end
      CMD_AND: alu_res = val_rn_in & val2;
      CMD_ORR: alu_res = val_rn_in | val2;
      CMD_EOR: alu_res = val_rn_in ^ val2;
      default: alu_res = '0;
    endcase
    if (is_add || is_sub) alu_res = sum[DATA_W-1:0];
    alu_flags[FLAG_N] = alu_res[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    if (is_add || is_sub) alu_flags[FLAG_C] = sum[DATA_W];
    if (is_add)
      alu_flags[FLAG_V] = (val_rn_in[DATA_W-1] == val2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != val_rn_in[DATA_W-1]);
    if (is_sub)
      alu_flags[FLAG_V] = (val_rn_in[DATA_W-1] != val2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != val_rn_in[DATA_W-1]);
  end

  // Payload headed for the output register: live ALU or finished MUL.
  always_comb begin
    nxt_res   = alu_res;
    nxt_flags = alu_flags;
    nxt_ctrl  = in_ctrl;
    nxt_rm    = val_rm_in;
    nxt_baddr = baddr_in;
    if (state == ST_DONE) begin
      nxt_res   = acc;
      nxt_flags = {acc[DATA_W-1], (acc == '0), status_out[FLAG_C], status_out[FLAG_V]};
      nxt_ctrl  = hold_ctrl;
      nxt_rm    = hold_rm;
      nxt_baddr = hold_baddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == CNT_W'(ITER - 1)) state_nxt = ST_DONE;
      ST_DONE: if (mul_load) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Shift-and-add multiplier retiring MUL_STEP_BITS multiplier bits per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      hold_ctrl  <= '0;
      hold_rm    <= '0;
      hold_baddr <= '0;
    end else if (accept && is_mul) begin
      mcand      <= val_rn_in;
      mplier     <= val2;
      acc        <= '0;
      cnt        <= '0;
      hold_ctrl  <= in_ctrl;
      hold_rm    <= val_rm_in;
      hold_baddr <= baddr_in;
    end else if (state == ST_BUSY) begin
      acc    <= acc + mul_part;
      mcand  <= mcand << MUL_STEP_BITS;
      mplier <= mplier >> MUL_STEP_BITS;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid        <= 1'b0;
      wb_en_out        <= 1'b0;
      mem_r_en_out     <= 1'b0;
      mem_w_en_out     <= 1'b0;
      dest_out         <= '0;
      alu_res_out      <= '0;
      val_rm_out       <= '0;
      branch_taken_out <= 1'b0;
      branch_addr_out  <= '0;
      status_out       <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (load) begin
        wb_en_out        <= nxt_ctrl.wb_en;
        mem_r_en_out     <= nxt_ctrl.mem_r_en;
        mem_w_en_out     <= nxt_ctrl.mem_w_en;
        dest_out         <= nxt_ctrl.dest;
        alu_res_out      <= nxt_res;
        val_rm_out       <= nxt_rm;
        branch_taken_out <= nxt_ctrl.b;
        branch_addr_out  <= nxt_baddr;
        if (nxt_ctrl.s && !nxt_ctrl.b) status_out <= nxt_flags;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_hs.sv
// Scoreboard bench for exe_stage_hs: directed instructions push expected
// results; a negedge monitor compares whatever MEM consumes.
module tb_exe_stage_hs;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in;
  logic [3:0]  exe_cmd_in, dest_in, dest_out, status_out;
  logic [11:0] shift_operand_in;
  logic [23:0] imm24_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in, alu_res_out, val_rm_out, branch_addr_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  st;
    logic [31:0] ba;
    logic        bt;
    logic        wb;
    logic        mr;
    logic [3:0]  dest;
    logic [31:0] rm;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0, npush = 0, npop = 0, last_wait = 0;
  logic [3:0] dest_ctr = 4'd1;
  logic       seen = 1'b0;

  exe_stage_hs #(.DATA_W(32), .MUL_STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .i_in(i_in), .exe_cmd_in(exe_cmd_in), .dest_in(dest_in),
    .shift_operand_in(shift_operand_in), .imm24_in(imm24_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .dest_out(dest_out), .alu_res_out(alu_res_out),
    .val_rm_out(val_rm_out), .branch_taken_out(branch_taken_out),
    .branch_addr_out(branch_addr_out), .status_out(status_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one instruction, wait for acceptance and record its expectation.
  task automatic issue(input logic [3:0] cmd, input logic wb, input logic s, input logic i,
                       input logic b, input logic mr, input logic [11:0] so,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] pc,
                       input logic [23:0] imm, input logic [31:0] eres, input logic [3:0] est,
                       input logic [31:0] eba, input int lat);
    exp_t e;
    int   w;
    exe_cmd_in = cmd; wb_en_in = wb; s_in = s; i_in = i; b_in = b;
    mem_r_en_in = mr; mem_w_en_in = 1'b0; shift_operand_in = so;
    val_rn_in = rn; val_rm_in = rm; pc_in = pc; imm24_in = imm; dest_in = dest_ctr;
    in_valid = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!in_ready && w < 200);
    last_wait = w;
    if (!in_ready) begin
      chk("accept_timeout", 32'(w), 32'd0);
    end else begin
      e.res = eres; e.st = est; e.ba = eba; e.bt = b; e.wb = wb; e.mr = mr;
      e.dest = dest_ctr; e.rm = rm; e.acc_cyc = cyc + 1; e.lat = lat;
      q.push_back(e);
      npush++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dest_ctr = dest_ctr + 4'd1;
  endtask

  // in_ready must stay low from MUL acceptance until its result appears.
  task automatic mul_wait();
    int bad = 0, n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (in_ready) bad++;
    end
    chk("mul_in_ready_low", 32'(bad), 32'd0);
    chk("mul_result_timeout", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", alu_res_out, 32'hdead_beef);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            e = q.pop_front();
            npop++;
            seen = 1'b0;
            chk("alu_res", alu_res_out, e.res);
            chk("status", {28'd0, status_out}, {28'd0, e.st});
            chk("branch_addr", branch_addr_out, e.ba);
            chk("branch_taken", {31'd0, branch_taken_out}, {31'd0, e.bt});
            chk("wb_en", {31'd0, wb_en_out}, {31'd0, e.wb});
            chk("mem_r_en", {31'd0, mem_r_en_out}, {31'd0, e.mr});
            chk("mem_w_en", {31'd0, mem_w_en_out}, 32'd0);
            chk("dest", {28'd0, dest_out}, {28'd0, e.dest});
            chk("val_rm", val_rm_out, e.rm);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int bad, n;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; b_in = 1'b0; s_in = 1'b0;
    i_in = 1'b0; exe_cmd_in = '0; dest_in = '0; shift_operand_in = '0; imm24_in = '0;
    pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd0);
    chk("rst_alu_res", alu_res_out, 32'd0);
    chk("rst_branch_addr", branch_addr_out, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b1; #1;
    chk("rst_in_ready_flush", {31'd0, in_ready}, 32'd0);
    flush = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // ALU: overflow, zero/carry, ADC carry-in, shifts, memory offset, logic
    issue(CMD_ADD, 1, 1, 1, 0, 0, 12'h001, 32'h7FFF_FFFF, 0, 32'h40, 24'h1, 32'h8000_0000, 4'b1001, 32'h44, 0);
    issue(CMD_SUB, 1, 1, 1, 0, 0, 12'h005, 32'd5, 0, 32'h40, 24'h1, 32'h0, 4'b0110, 32'h44, 0);
    issue(CMD_ADC, 1, 1, 1, 0, 0, 12'h001, 32'd1, 0, 32'h40, 24'h1, 32'd3, 4'b0000, 32'h44, 0);
    issue(CMD_MOV, 1, 0, 0, 0, 0, 12'h260, 32'd0, 32'h8000_0001, 32'h40, 24'h1, 32'h1800_0000, 4'b0000, 32'h44, 0);
    issue(CMD_MOV, 1, 0, 1, 0, 0, 12'h4FF, 32'd0, 0, 32'h40, 24'h1, 32'hFF00_0000, 4'b0000, 32'h44, 0);
    issue(CMD_ADD, 1, 0, 0, 0, 1, 12'h123, 32'h1000, 32'h55, 32'h40, 24'h1, 32'h1123, 4'b0000, 32'h44, 0);
    issue(CMD_ORR, 1, 1, 0, 0, 0, 12'h240, 32'h0F, 32'hF000_0000, 32'h40, 24'h1, 32'hFF00_000F, 4'b1000, 32'h44, 0);
    // Branch with S set must leave status alone
    issue(CMD_SUB, 0, 1, 1, 1, 0, 12'h005, 32'd5, 0, 32'h100, 24'hFFFFFE, 32'h0, 4'b1000, 32'hF8, 0);

    // Iterative multiply
    issue(CMD_MUL, 1, 1, 1, 0, 0, 12'h801, 32'h1_0000, 0, 32'h40, 24'h1, 32'h0, 4'b0100, 32'h44, 33);
    mul_wait();
    issue(CMD_MUL, 1, 0, 1, 0, 0, 12'h006, 32'd7, 0, 32'h40, 24'h1, 32'd42, 4'b0100, 32'h44, 33);
    mul_wait();

    // Backpressure: result held five cycles, then consume-and-accept
    out_ready = 1'b0;
    issue(CMD_ADD, 1, 0, 1, 0, 0, 12'h005, 32'd10, 0, 32'h40, 24'h1, 32'd15, 4'b0100, 32'h44, 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!out_valid || alu_res_out !== 32'd15 || in_ready) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    issue(CMD_EOR, 1, 1, 1, 0, 0, 12'h00F, 32'hFF, 0, 32'h40, 24'h1, 32'hF0, 4'b0000, 32'h44, 0);
    chk("accept_on_ready_edge", 32'(last_wait), 32'd1);

    // Flush mid-MUL: no result, no status update, FSM back to IDLE
    @(negedge clk);
    while (out_valid) @(negedge clk);
    @(posedge clk); #1;
    exe_cmd_in = CMD_MUL; s_in = 1'b1; i_in = 1'b1; b_in = 1'b0; mem_r_en_in = 1'b0;
    shift_operand_in = 12'h000; val_rn_in = 32'd0; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_mul_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_accept", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_status", {28'd0, status_out}, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("flush_no_output", 32'(bad), 32'd0);
    chk("flush_status_after", {28'd0, status_out}, 32'd0);
    @(posedge clk); #1;
    issue(CMD_ADD, 1, 0, 1, 0, 0, 12'h003, 32'd2, 0, 32'h40, 24'h1, 32'd5, 4'b0000, 32'h44, 0);

    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    chk("pop_count", 32'(npop), 32'(npush));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage_hs.md
# exe_stage_hs

Parametrised, handshaked execute stage for the ARM pipeline. It does the following between ID/EX and EX/MEM:
- generates the second operand (immediate rotate, register shift, or memory offset);
- executes ALU and iterative multiply commands;
- owns the NZCV status register;
- computes branch targets;
- registers the results toward MEM.

Unlike the prior combinational execute stage, it has an internal status register with an S-gated update, a multi-cycle MUL path, valid/ready backpressure and a flush input.

## Interface
Parameters:
- DATA_W, 32, datapath width; power of two, ≥16.
- MUL_STEP_BITS, 1, multiplier bits retired per cycle; must divide DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous kill of in-flight and output-register contents.
- in_valid  in  1  ID/EX holds an instruction.
- in_ready  out  1  stage accepts this cycle.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in  in  1 each  decoded controls.
- exe_cmd_in  in  4  command (exe_pkg encoding).
- dest_in  in  4  destination register.
- shift_operand_in  in  12  ARM shifter operand.
- imm24_in  in  24  branch offset.
- pc_in, val_rn_in, val_rm_in  in  DATA_W each  operands.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  MEM consumes this cycle.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls.
- dest_out  out  4  registered destination.
- alu_res_out, val_rm_out  out  DATA_W each  registered result and store data.
- branch_taken_out  out  1  registered b_in.
- branch_addr_out  out  DATA_W  registered target.
- status_out  out  4  NZCV register (N=bit3 … V=bit0).

## Operation
Val2 selection:
- Memory op (mem_r_en_in|mem_w_en_in): zero-extended shift_operand_in[11:0].
- Otherwise, i_in=1: imm8 [7:0] rotated right by 2×[11:8].
- Otherwise, i_in=0: val_rm_in shifted by [11:7], type [6:5]: LSL, LSR, ASR, ROR. Shift amounts are taken modulo DATA_W.

ALU commands (exe_pkg):
- MOV, MVN.
- ADD, ADC: carry-in is the internal C.
- SUB, SBC, AND, ORR, EOR.
- MUL: low DATA_W bits of val_rn×val2.
- LDR/STR use ADD.

Flags:
- N = result msb; Z = result==0.
- ADD/ADC: C = carry-out; V = signed overflow.
- SUB/SBC: C = NOT borrow; V = signed overflow.
- Logical, move and MUL: C and V unchanged.

Status register update:
- Written with the new flags only when a non-branch instruction with s_in=1 enters the output register.
- A flushed instruction never updates it.

Branch:
- branch_addr = pc_in + (sign-extended imm24 << 2), truncated to DATA_W.
- Status is unchanged.

FSM states and transitions:
- IDLE → BUSY: accept with MUL.
- BUSY → DONE: after DATA_W/MUL_STEP_BITS iterations.
- DONE → IDLE: when the output register loads.
- Any state → IDLE: flush.

## Timing
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Non-MUL latency: 1 cycle. Accepted at edge k; out_valid and data are visible after edge k.
- MUL latency:
  - Accepted at edge k; out_valid rises after edge k + DATA_W/MUL_STEP_BITS + 1.
  - DONE holds the result while MEM stalls.
  - in_ready stays 0 from BUSY entry until the result is loaded.
- out_valid stays asserted, with data stable, until out_ready is high at an edge.
- Simultaneous consume and accept:
  - the output register reloads in the same edge;
  - no bubble is inserted.
- flush (wins over everything):
  - clears out_valid;
  - returns the FSM to IDLE;
  - blocks acceptance that cycle;
  - leaves status unchanged.
- Reset values:
  - out_valid = 0; all registered data and control outputs = 0.
  - status_out = 4'b0000; FSM in IDLE.
  - in_ready = !flush.
- Reset asserted mid-MUL aborts it with no status change.

## Structure
- exe_pkg holds:
  - exe_cmd localparams;
  - shift-type codes;
  - the NZCV bit-index constants;
  - the state enum.
- Sub-module val2_gen (parametrised by DATA_W) provides the combinational shifter/immediate unit.
- The multiplier iteration, FSM, status register and output register live in exe_stage_hs.

## Test plan
Unless stated, DATA_W=32 and MUL_STEP_BITS=1.
1. ADD with s_in=1, val_rn=0x7FFFFFFF, immediate 1:
   - alu_res_out=0x80000000; status_out=4'b1001 one cycle after acceptance.
2. SUB with s_in=1, 5−5, then ADC 1+1:
   - SUB: Z=1, C=1, status 4'b0110.
   - ADC: result=3.
3. MUL 0x10000×0x10000, then MUL 7×6:
   - First result 0x00000000, Z=1; second result 42.
   - Each out_valid arrives 33 cycles after acceptance; in_ready=0 throughout.
4. out_ready held low 5 cycles with out_valid=1:
   - Outputs are stable and in_ready=0.
   - Next instruction accepted on the edge out_ready returns.
5. Branch with pc=0x100, imm24=0xFFFFFE:
   - branch_addr_out=0x0F8; branch_taken_out=1; status unchanged.
6. flush mid-MUL with s_in=1:
   - No out_valid; status unchanged.
   - FSM in IDLE; in_ready=1 the following cycle.
